// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: default widths and
// the hazard FSM state encoding.
package hazard_unit_pkg;

   // Register index width of the core (architectural register file of 32).
   localparam int REG_NUM_WIDTH_DEF = 5;

   // Default width of the stall/flush performance counters.
   localparam int CNT_WIDTH_DEF = 16;

   // Hazard FSM states; encodings are shared with debug tooling.
   typedef enum logic [1:0] {
      HZ_RUN     = 2'd0,
      HZ_LDSTALL = 2'd1,
      HZ_MEMWAIT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter: counts cycles with en=1 and sticks at all-ones.
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] r_count;

   // Count enabled cycles, holding at the maximum value instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (en && (r_count != '1)) begin
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage core. Detects load-use hazards,
// taken-branch redirects and data-memory wait states, and produces the
// stall / flush / freeze controls for PC, IF/ID and ID/EX.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_NUM_WIDTH = REG_NUM_WIDTH_DEF,
   parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [REG_NUM_WIDTH-1:0] idReadNum0,
   input  logic [REG_NUM_WIDTH-1:0] idReadNum1,
   input  logic [REG_NUM_WIDTH-1:0] idWriteNum,
   input  logic                     idIsLoad,
   input  logic                     idValid,
   input  logic                     exBranchTaken,
   input  logic                     memReq,
   input  logic                     memReady,
   output logic                     stallPC,
   output logic                     stallIFID,
   output logic                     flushIFID,
   output logic                     flushIDEX,
   output logic                     freezeAll,
   output logic [CNT_WIDTH-1:0]     stallCount,
   output logic [CNT_WIDTH-1:0]     flushCount
);

   logic [REG_NUM_WIDTH-1:0] r_exRd;
   logic [REG_NUM_WIDTH-1:0] r_memRd;
   logic                     r_exLd;
   hz_state_e                r_state;
   hz_state_e                w_stateNext;
   logic                     w_loadUse;
   logic                     w_memWait;
   logic                     w_unused_memRd;

   // Register x0 never creates a hazard; a doubled source is still one hazard.
   assign w_loadUse = r_exLd && (r_exRd != '0) && idValid &&
                      ((r_exRd == idReadNum0) || (r_exRd == idReadNum1));

   assign w_memWait = memReq && !memReady;

   // The MEM-stage destination is tracked for the core's view of the pipe but
   // no hazard term consumes it yet.
   assign w_unused_memRd = ^r_memRd;

   // Shadow of EX and MEM destinations; holds while the whole pipe is frozen.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_exRd  <= '0;
         r_exLd  <= 1'b0;
         r_memRd <= '0;
      end else if (!freezeAll) begin
         r_exRd  <= (flushIDEX || !idValid) ? '0 : idWriteNum;
         r_exLd  <= (flushIDEX || !idValid) ? 1'b0 : idIsLoad;
         r_memRd <= r_exRd;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= HZ_RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // FSM next state: memory wait dominates; a load-use stall lasts one cycle.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         HZ_RUN: begin
            if (w_memWait) begin
               w_stateNext = HZ_MEMWAIT;
            end else if (w_loadUse && !exBranchTaken) begin
               w_stateNext = HZ_LDSTALL;
            end else begin
               w_stateNext = HZ_RUN;
            end
         end
         HZ_LDSTALL: w_stateNext = w_memWait ? HZ_MEMWAIT : HZ_RUN;
         HZ_MEMWAIT: w_stateNext = w_memWait ? HZ_MEMWAIT : HZ_RUN;
         default:    w_stateNext = HZ_RUN;
      endcase
   end

   // Output decode by priority memWait > branch > load-use; all low in reset.
   always_comb begin
      stallPC   = 1'b0;
      stallIFID = 1'b0;
      flushIFID = 1'b0;
      flushIDEX = 1'b0;
      freezeAll = 1'b0;
      if (!reset) begin
         if (w_memWait) begin
            freezeAll = 1'b1;
            stallPC   = 1'b1;
            stallIFID = 1'b1;
         end else if (exBranchTaken) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
         end else if (w_loadUse) begin
            stallPC   = 1'b1;
            stallIFID = 1'b1;
            flushIDEX = 1'b1;
         end
      end
   end

   sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (stallPC),
      .count (stallCount)
   );

   sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (flushIFID),
      .count (flushCount)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural model. A second
// instance with 4-bit counters shares the inputs to exercise saturation.
module tb_hazard_unit;
   import hazard_unit_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] idReadNum0, idReadNum1, idWriteNum;
   logic       idIsLoad, idValid, exBranchTaken, memReq, memReady;

   logic        stallPC, stallIFID, flushIFID, flushIDEX, freezeAll;
   logic [15:0] stallCount, flushCount;
   logic        s4_stallPC, s4_stallIFID, s4_flushIFID, s4_flushIDEX, s4_freezeAll;
   logic [3:0]  s4_stallCount, s4_flushCount;

   logic [4:0] w_o, w_o4;
   assign w_o  = {freezeAll, stallPC, stallIFID, flushIFID, flushIDEX};
   assign w_o4 = {s4_freezeAll, s4_stallPC, s4_stallIFID, s4_flushIFID, s4_flushIDEX};

   localparam logic [4:0] O_NONE = 5'b00000;
   localparam logic [4:0] O_LU   = 5'b01101;
   localparam logic [4:0] O_BR   = 5'b00011;
   localparam logic [4:0] O_MW   = 5'b11100;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_unit #(.REG_NUM_WIDTH(5), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .idReadNum0(idReadNum0), .idReadNum1(idReadNum1), .idWriteNum(idWriteNum),
      .idIsLoad(idIsLoad), .idValid(idValid), .exBranchTaken(exBranchTaken),
      .memReq(memReq), .memReady(memReady),
      .stallPC(stallPC), .stallIFID(stallIFID), .flushIFID(flushIFID),
      .flushIDEX(flushIDEX), .freezeAll(freezeAll),
      .stallCount(stallCount), .flushCount(flushCount)
   );

   hazard_unit #(.REG_NUM_WIDTH(5), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset),
      .idReadNum0(idReadNum0), .idReadNum1(idReadNum1), .idWriteNum(idWriteNum),
      .idIsLoad(idIsLoad), .idValid(idValid), .exBranchTaken(exBranchTaken),
      .memReq(memReq), .memReady(memReady),
      .stallPC(s4_stallPC), .stallIFID(s4_stallIFID), .flushIFID(s4_flushIFID),
      .flushIDEX(s4_flushIDEX), .freezeAll(s4_freezeAll),
      .stallCount(s4_stallCount), .flushCount(s4_flushCount)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] w, input logic ld, input logic v,
                        input logic br, input logic mq, input logic mr);
      reset = rst; idReadNum0 = a; idReadNum1 = b; idWriteNum = w;
      idIsLoad = ld; idValid = v; exBranchTaken = br; memReq = mq; memReady = mr;
   endtask

   // Called at posedge+1: settle, compare outputs, advance one clock.
   task automatic cyc(input string tag, input logic [4:0] exp_o);
      #3;
      chk({tag, " outs"}, w_o, exp_o);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic [4:0] r0, r1, wr;
      logic       ld, v, br, mq, mr;
      logic [4:0] exp_o;
      int         exp_sc, exp_fc;
   } vec_t;

   vec_t tbl[16];

   // Behavioural model state for the random phase.
   int m_exRd, m_exLd, m_state, m_sc, m_fc, m_sc4, m_fc4;

   initial begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      //           rst r0 r1 wr ld v br mq mr  outs   sc fc
      tbl[0]  = '{1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_NONE, 0, 0};
      tbl[1]  = '{1'b0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 0, 0};
      tbl[2]  = '{1'b0, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   1, 0};
      tbl[3]  = '{1'b0, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 1, 0};
      tbl[4]  = '{1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 1, 0};
      tbl[5]  = '{1'b0, 5'd5, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BR,   1, 1};
      tbl[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 1, 1};
      tbl[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 1, 1};
      tbl[8]  = '{1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 1, 1};
      tbl[9]  = '{1'b0, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,   2, 1};
      tbl[10] = '{1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_MW,   3, 1};
      tbl[11] = '{1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_MW,   4, 1};
      tbl[12] = '{1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_MW,   5, 1};
      tbl[13] = '{1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, O_NONE, 5, 1};
      tbl[14] = '{1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 5, 1};
      tbl[15] = '{1'b0, 5'd2, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE, 5, 1};

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].wr, tbl[i].ld, tbl[i].v,
               tbl[i].br, tbl[i].mq, tbl[i].mr);
         cyc($sformatf("tbl[%0d]", i), tbl[i].exp_o);
         chk($sformatf("tbl[%0d] stallCount", i), stallCount, tbl[i].exp_sc);
         chk($sformatf("tbl[%0d] flushCount", i), flushCount, tbl[i].exp_fc);
      end

      // Memory wait defers a pending load-use and freezes the shadow.
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("mw lw", O_NONE);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         cyc($sformatf("mw wait%0d", k), O_MW);
         chk($sformatf("mw state%0d", k), int'(dut.r_state), 2);
         chk($sformatf("mw exRd%0d", k), dut.r_exRd, 7);
         chk($sformatf("mw exLd%0d", k), dut.r_exLd, 1);
      end
      chk("mw stallCount", stallCount, 3);
      drive(1'b0, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      cyc("mw release", O_LU);
      chk("mw release state", int'(dut.r_state), 0);
      chk("mw release stallCount", stallCount, 4);
      chk("mw release exRd", dut.r_exRd, 0);

      // Load-use moves RUN to LDSTALL, which returns to RUN.
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("ld lw", O_NONE);
      drive(1'b0, 5'd1, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("ld use", O_LU);
      chk("ld state", int'(dut.r_state), 1);
      cyc("ld after", O_NONE);
      chk("ld state back", int'(dut.r_state), 0);

      // Reset while frozen clears state and both counters.
      do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("rst br", O_BR);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("rst mw0", O_MW);
      cyc("rst mw1", O_MW);
      chk("rst pre flushCount", flushCount, 1);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc("rst during mw", O_NONE);
      chk("rst state", int'(dut.r_state), 0);
      chk("rst stallCount", stallCount, 0);
      chk("rst flushCount", flushCount, 0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("rst after", O_NONE);

      // Twenty load-use events: 4-bit counter saturates, 16-bit keeps counting.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         #3; @(posedge clk); #1;
         drive(1'b0, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         #3; @(posedge clk); #1;
      end
      chk("sat stallCount4", s4_stallCount, 15);
      chk("sat stallCount16", stallCount, 20);

      // Randomized traffic against the behavioural model.
      do_reset();
      m_exRd = 0; m_exLd = 0; m_state = 0; m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
      for (int c = 0; c < 400; c++) begin
         logic       rst, ld, v, br, mq, mr, mw, lu;
         logic [4:0] a, b, w, eo;
         rst = ($urandom_range(0, 39) == 0);
         a   = 5'($urandom_range(0, 7));
         b   = 5'($urandom_range(0, 7));
         w   = 5'($urandom_range(0, 7));
         ld  = 1'($urandom_range(0, 1));
         v   = ($urandom_range(0, 4) != 0);
         br  = ($urandom_range(0, 6) == 0);
         mq  = ($urandom_range(0, 2) == 0);
         mr  = 1'($urandom_range(0, 1));
         drive(rst, a, b, w, ld, v, br, mq, mr);

         mw = mq && !mr;
         lu = (m_exLd != 0) && (m_exRd != 0) && v && ((m_exRd == int'(a)) || (m_exRd == int'(b)));
         if (rst)     eo = O_NONE;
         else if (mw) eo = O_MW;
         else if (br) eo = O_BR;
         else if (lu) eo = O_LU;
         else         eo = O_NONE;

         #3;
         chk($sformatf("rnd%0d outs", c), w_o, eo);
         chk($sformatf("rnd%0d outs4", c), w_o4, eo);
         @(posedge clk);
         #1;

         if (rst) begin
            m_exRd = 0; m_exLd = 0; m_state = 0;
            m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
         end else begin
            if (!mw) begin
               m_exRd = (eo[0] || !v) ? 0 : int'(w);
               m_exLd = (eo[0] || !v) ? 0 : int'(ld);
            end
            if (eo[3]) begin
               m_sc  = (m_sc  < 65535) ? m_sc  + 1 : m_sc;
               m_sc4 = (m_sc4 < 15)    ? m_sc4 + 1 : m_sc4;
            end
            if (eo[1]) begin
               m_fc  = (m_fc  < 65535) ? m_fc  + 1 : m_fc;
               m_fc4 = (m_fc4 < 15)    ? m_fc4 + 1 : m_fc4;
            end
            if (mw)                               m_state = 2;
            else if (m_state == 0 && lu && !br)   m_state = 1;
            else                                  m_state = 0;
         end
         chk($sformatf("rnd%0d stallCount", c), stallCount, m_sc);
         chk($sformatf("rnd%0d flushCount", c), flushCount, m_fc);
         chk($sformatf("rnd%0d stallCount4", c), s4_stallCount, m_sc4);
         chk($sformatf("rnd%0d flushCount4", c), s4_flushCount, m_fc4);
         chk($sformatf("rnd%0d state", c), int'(dut.r_state), m_state);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
